// File: rtl/cp0_defs.sv
// rtl/cp0_defs.sv - CP0 register numbers, exception codes and reset constants
// Purpose: shared definitions for the CP0 register file and its timer.
// Ports: none (package).
package cp0_defs;

  // CP0 register numbers
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;
  localparam logic [4:0] CP0_CONFIG  = 5'd16;

  // Exception type codes signalled by the memory stage
  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_RI        = 32'h0000_000A;
  localparam logic [31:0] EXC_OV        = 32'h0000_000C;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000D;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000E;

  // ExcCode values written to Cause[6:2]
  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;
  localparam logic [4:0] EXCCODE_TRAP = 5'd13;

  // Reset constants
  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
  localparam logic [31:0] CONFIG_RESET = 32'h0000_8000;
  localparam logic [31:0] PRID_RESET   = 32'h004C_0102;

  // Software-writable Cause bits: IV[23], WP[22], IP[9:8]
  localparam logic [31:0] CAUSE_WMASK  = 32'h00C0_0300;

  typedef struct packed {
    logic       hit;
    logic [4:0] code;
  } exc_info_t;

  // Maps an exception type to its ExcCode; hit=0 for none/eret/unknown.
  function automatic exc_info_t exc_decode(input logic [31:0] t);
    exc_info_t r;
    r.hit  = 1'b1;
    r.code = EXCCODE_INT;
    case (t)
      EXC_INTERRUPT: r.code = EXCCODE_INT;
      EXC_SYSCALL:   r.code = EXCCODE_SYS;
      EXC_RI:        r.code = EXCCODE_RI;
      EXC_OV:        r.code = EXCCODE_OV;
      EXC_TRAP:      r.code = EXCCODE_TRAP;
      default:       r.hit  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - CP0 Count/Compare timer
// Purpose: free-running Count, Compare register and sticky timer interrupt.
// Ports: clk, rst (sync, active-high); we_i/waddr_i/data_i software write;
//        count_o, compare_o, timer_int_o registered outputs.
module cp0_timer
  import cp0_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_o     <= 32'd0;
      compare_o   <= 32'd0;
      timer_int_o <= 1'b0;
    end else begin
      // A software Count write replaces this cycle's increment.
      if (we_i && waddr_i == CP0_COUNT) begin
        count_o <= data_i;
      end else begin
        count_o <= count_o + 32'd1;
      end

      // Writing Compare acknowledges the interrupt, even over a match.
      if (we_i && waddr_i == CP0_COMPARE) begin
        compare_o   <= data_i;
        timer_int_o <= 1'b0;
      end else if (compare_o != 32'd0 && count_o == compare_o) begin
        timer_int_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_reg.sv
// rtl/cp0_reg.sv - MIPS32 coprocessor-0 register file
// Purpose: Count/Compare timer, Status/Cause/EPC with exception recording,
//          PRId/Config constants and a combinational read port.
// Ports: clk, rst (sync, active-high); we_i/waddr_i/data_i write port;
//        raddr_i/data_o read port; int_i hardware interrupts;
//        excepttype_i/current_inst_addr_i/is_in_delayslot_i exception info;
//        count_o..prid_o register views; timer_int_o timer interrupt.
module cp0_reg
  import cp0_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  cp0_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .data_i      (data_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .timer_int_o (timer_int_o)
  );

  assign config_o = CONFIG_RESET;
  assign prid_o   = PRID_RESET;

  logic [31:0] status_n;
  logic [31:0] cause_n;
  logic [31:0] epc_n;
  exc_info_t   exc;

  // Software write first, then the exception update layered on top so
  // the exception owns any field both touch. The exception sees the
  // post-write EXL.
  always_comb begin
    status_n = status_o;
    cause_n  = cause_o;
    epc_n    = epc_o;
    exc      = exc_decode(excepttype_i);

    cause_n[15:10] = int_i;

    if (we_i) begin
      case (waddr_i)
        CP0_STATUS: status_n = data_i;
        CP0_EPC:    epc_n    = data_i;
        CP0_CAUSE:  cause_n  = (cause_n & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        default:    ;
      endcase
    end

    if (exc.hit) begin
      // Nested exceptions keep the original return address and BD.
      if (!status_n[1]) begin
        epc_n       = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                        : current_inst_addr_i;
        cause_n[31] = is_in_delayslot_i;
      end
      status_n[1]  = 1'b1;
      cause_n[6:2] = exc.code;
    end else if (excepttype_i == EXC_ERET) begin
      status_n[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_o <= STATUS_RESET;
      cause_o  <= 32'd0;
      epc_o    <= 32'd0;
    end else begin
      status_o <= status_n;
      cause_o  <= cause_n;
      epc_o    <= epc_n;
    end
  end

  always_comb begin
    case (raddr_i)
      CP0_COUNT:   data_o = count_o;
      CP0_COMPARE: data_o = compare_o;
      CP0_STATUS:  data_o = status_o;
      CP0_CAUSE:   data_o = cause_o;
      CP0_EPC:     data_o = epc_o;
      CP0_PRID:    data_o = prid_o;
      CP0_CONFIG:  data_o = config_o;
      default:     data_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_reg.sv
// tb/tb_cp0_reg.sv - scoreboard bench for cp0_reg
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  always #5 clk = ~clk;

  cp0_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .data_i              (data_i),
    .raddr_i             (raddr_i),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .data_o              (data_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .prid_o              (prid_o),
    .timer_int_o         (timer_int_o)
  );

  typedef struct {
    logic [31:0] count, compare, status, cause, epc, cfg, prid, rdata;
    logic        ti;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m[0:31];   // reference registers indexed by CP0 number
  logic        m_ti;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd9 || (a >= 5'd11 && a <= 5'd16)) return m[a];
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    m[12] = 32'h1000_0000;
    m[15] = 32'h004C_0102;
    m[16] = 32'h0000_8000;
    m_ti  = 1'b0;
  endtask

  // Drives one cycle of inputs, advances the reference model and queues
  // what the DUT must show after the coming edge.
  task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] d, input logic [4:0] ra,
                       input logic [5:0] irq, input logic [31:0] et,
                       input logic [31:0] pc, input logic ds);
    logic [31:0] nx[0:31];
    logic        hit;
    logic [4:0]  code;
    exp_t        e;
    @(negedge clk);
    rst = r; we_i = w; waddr_i = wa; data_i = d; raddr_i = ra;
    int_i = irq; excepttype_i = et; current_inst_addr_i = pc; is_in_delayslot_i = ds;
    if (r) begin
      model_reset();
    end else begin
      nx = m;
      nx[9] = m[9] + 32'd1;
      if (w && wa == 5'd11) m_ti = 1'b0;
      else if (m[11] != 0 && m[9] == m[11]) m_ti = 1'b1;
      nx[13][15:10] = irq;
      if (w) begin
        case (wa)
          5'd9, 5'd11, 5'd12, 5'd14: nx[wa] = d;
          5'd13: begin
            nx[13][9:8]   = d[9:8];
            nx[13][23:22] = d[23:22];
          end
          default: ;
        endcase
      end
      hit = 1'b1;
      code = 5'd0;
      case (et)
        32'h1: code = 5'd0;
        32'h8: code = 5'd8;
        32'hA: code = 5'd10;
        32'hD: code = 5'd13;
        32'hC: code = 5'd12;
        default: hit = 1'b0;
      endcase
      if (hit) begin
        if (nx[12][1] == 1'b0) begin
          nx[14] = ds ? pc - 32'd4 : pc;
          nx[13][31] = ds;
        end
        nx[12][1] = 1'b1;
        nx[13][6:2] = code;
      end else if (et == 32'hE) begin
        nx[12][1] = 1'b0;
      end
      m = nx;
    end
    e.count = m[9]; e.compare = m[11]; e.status = m[12]; e.cause = m[13];
    e.epc = m[14]; e.cfg = m[16]; e.prid = m[15]; e.ti = m_ti;
    e.rdata = model_read(ra);
    q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [4:0] ra);
    for (int i = 0; i < n; i++) drive(0, 0, 5'd0, 32'd0, ra, 6'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Monitor: compares the queued expectation just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count", count_o, e.count);
        chk("compare", compare_o, e.compare);
        chk("status", status_o, e.status);
        chk("cause", cause_o, e.cause);
        chk("epc", epc_o, e.epc);
        chk("config", config_o, e.cfg);
        chk("prid", prid_o, e.prid);
        chk("timer_int", {31'd0, timer_int_o}, {31'd0, e.ti});
        chk("data_o", data_o, e.rdata);
      end
    end
  end

  initial begin
    logic [31:0] ets[10];
    rst = 1'b1; we_i = 0; waddr_i = 0; data_i = 0; raddr_i = 0; int_i = 0;
    excepttype_i = 0; current_inst_addr_i = 0; is_in_delayslot_i = 0;
    model_reset();

    // Reset then idle: count reaches 10
    drive(1, 0, 5'd0, 32'd0, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0);
    idle(10, 5'd15);

    // Timer: Compare=20 written at Count=5, then cleared by Compare=100
    drive(1, 0, 5'd0, 32'd0, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0);
    idle(5, 5'd9);
    drive(0, 1, 5'd11, 32'd20, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0);
    idle(18, 5'd9);
    drive(0, 1, 5'd11, 32'd100, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0);
    idle(2, 5'd11);

    // Cause masked write with interrupt lines
    drive(0, 1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'b000101, 32'd0, 32'd0, 1'b0);
    idle(1, 5'd13);

    // Syscall in delay slot, nested overflow, eret
    drive(0, 0, 5'd0, 32'd0, 5'd14, 6'd0, 32'h8, 32'hBFC0_0100, 1'b1);
    drive(0, 0, 5'd0, 32'd0, 5'd14, 6'd0, 32'hC, 32'h0000_0200, 1'b0);
    drive(0, 0, 5'd0, 32'd0, 5'd12, 6'd0, 32'hE, 32'd0, 1'b0);

    // EPC write colliding with an interrupt, then unmapped read
    drive(0, 1, 5'd14, 32'h1234, 5'd14, 6'd0, 32'h1, 32'h400, 1'b0);
    idle(1, 5'd7);

    // Count wrap
    drive(0, 1, 5'd9, 32'hFFFF_FFFE, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0);
    idle(3, 5'd9);

    // Randomized traffic
    ets = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h8, 32'hA, 32'hC, 32'hD, 32'hE, 32'h5};
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      logic [4:0]  wa;
      wa = 5'($urandom_range(8, 17));
      d  = $urandom;
      // Small Compare/Count values so matches actually happen
      if ((wa == 5'd11 || wa == 5'd9) && $urandom_range(0, 1) == 1) d = $urandom_range(0, 40);
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), wa, d,
            5'($urandom_range(0, 17)), 6'($urandom), ets[$urandom_range(0, 9)],
            $urandom, 1'($urandom));
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_reg.md
# cp0_reg

Coprocessor-0 register file of the MIPS32 core: the receiving end of the write-back CP0 write port (`we`/`waddr`/`data`) driven out of the MEM/WB pipeline register. Holds Count, Compare, Status, Cause, EPC, PRId and Config. Runs the Count/Compare timer, latches hardware interrupt lines, and records exception state on the exception type signalled from the memory stage. Provides a combinational read port to the execute stage and the Status/Cause/EPC views to the control unit.

## Interface
- No parameters. Reset values and register addresses are fixed constants (see Structure).
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `we_i` in 1: CP0 write enable from write-back.
- `waddr_i` in 5: CP0 write register number.
- `data_i` in 32: CP0 write data.
- `raddr_i` in 5: CP0 read register number.
- `int_i` in 6: hardware interrupt lines, sampled every cycle.
- `excepttype_i` in 32: exception type from memory stage; 0 = none.
- `current_inst_addr_i` in 32: PC of the excepting instruction.
- `is_in_delayslot_i` in 1: excepting instruction sits in a delay slot.
- `data_o` out 32: read data for `raddr_i`, combinational.
- `count_o`, `compare_o`, `status_o`, `cause_o`, `epc_o`, `config_o`, `prid_o` out 32 each: registered views.
- `timer_int_o` out 1: timer interrupt, registered.

## Operation
- Reset values: Count 0, Compare 0, Status 32'h1000_0000 (CU0=1), Cause 0, EPC 0, Config 32'h0000_8000 (BE=1), PRId 32'h004C_0102, `timer_int_o` 0.
- Every non-reset cycle: Count <= Count+1, wrapping 32'hFFFF_FFFF -> 0. Cause[15:10] <= `int_i`.
- Timer: when Compare != 0 and Count == Compare, `timer_int_o` <= 1. The flag stays set until Compare is written.
- Software write (`we_i`=1), by `waddr_i`:
  - 9 (Count): whole register. Overrides the increment in that cycle.
  - 11 (Compare): whole register. Also clears `timer_int_o`; the clear takes priority over a match in the same cycle.
  - 12 (Status): whole register.
  - 14 (EPC): whole register.
  - 13 (Cause): only IP[9:8], WP[22], IV[23] are written; other bits are kept.
  - 15, 16 and unknown addresses: write ignored.
- Exception update is applied after the software write in the same cycle. On a field conflict, the exception wins.
- `excepttype_i` codes and ExcCode written to Cause[6:2]:
  - 32'h1 interrupt -> 0
  - 32'h8 syscall -> 8
  - 32'hA reserved instruction -> 10
  - 32'hD trap -> 13
  - 32'hC overflow -> 12
- For any of these codes:
  - If Status.EXL[1] == 0: EPC <= `current_inst_addr_i` − 4 when in a delay slot, else `current_inst_addr_i`; Cause.BD[31] <= `is_in_delayslot_i`.
  - If Status.EXL[1] == 1: EPC and BD are unchanged.
  - In both cases: Status.EXL <= 1 and ExcCode is written.
- 32'hE (eret): Status.EXL <= 0; nothing else changes.
- Other non-zero codes: no effect.
- Read port: `data_o` = the register selected by `raddr_i` (9, 11–16); any other address returns 0.
  - No internal write-to-read bypass. Forwarding is done upstream.

## Timing
- A write or exception is visible on the outputs and on `data_o` one cycle after the edge that takes it.
- `timer_int_o` rises one cycle after the cycle in which Count == Compare.
- Reset mid-operation: every register returns to its reset value on the next edge. A pending timer interrupt is lost.

## Structure
- Shared package `cp0_defs` holds:
  - Register numbers: CP0_COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14, PRID=15, CONFIG=16.
  - Exception type codes and ExcCode values.
  - Reset constants for Status, Config and PRId.
- One sub-module is natural: `cp0_timer`, owning Count, Compare and `timer_int_o`, with the write-priority rules above.
- Status, Cause and EPC logic stays in the top module.

## Test plan
- Reset, then 10 idle cycles -> `count_o`=10, `status_o`=32'h1000_0000, `prid_o`=32'h004C_0102, `timer_int_o`=0.
- Write Compare=20 at Count=5 -> `timer_int_o`=1 at Count=21. Write Compare=100 -> `timer_int_o`=0 on the next cycle.
- Write Cause=32'hFFFF_FFFF with `int_i`=6'b000101 -> `cause_o`=32'h00C0_1700.
- Syscall at PC 32'hBFC0_0100 with delay slot = 1 and EXL=0 -> EPC=32'hBFC0_00FC, BD=1, ExcCode=8, EXL=1.
- Second overflow while EXL=1 at PC 32'h200 -> EPC and BD unchanged, ExcCode=12. Then eret -> EXL=0.
- Same cycle: write EPC=32'h1234 and an interrupt at PC 32'h400 with EXL=0 -> EPC=32'h400. Read address 7 -> `data_o`=0.
